req_encoder_nbit: RTL

Sequential one-hot/multi-hot to binary encoder; it is the encode-side counterpart of the team's N-bit decoder. It captures a 2**N-bit request vector in one cycle, then emits the index of every set bit, lowest index first, one index per accepted handshake. It sits between request-collection logic and any consumer that needs binary indices, such as a decoder-driven select or a mux address.

---
 rtl/req_encoder_nbit_pkg.sv | 12 +
 rtl/lsb_find_nbit.sv | 35 +++
 rtl/req_encoder_nbit.sv | 80 ++++++++
 3 files changed

// File: rtl/req_encoder_nbit_pkg.sv
// Shared definitions for the sequential request encoder: FSM encodings and
// the request-vector width helper.
package req_encoder_nbit_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    function automatic int vec_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/lsb_find_nbit.sv
// Combinational lowest-set-bit finder over an ascending request vector.
// Also flags whether any bit is set and whether exactly one bit is set.
module lsb_find_nbit
    import req_encoder_nbit_pkg::*;
#(
    parameter int N = 3,
    localparam int W = vec_width(N)
) (
    input  logic [0:W-1] v,
    output logic [N-1:0] pos,
    output logic         any,
    output logic         one
);

    logic multi;

    always_comb begin
        pos   = '0;
        any   = 1'b0;
        multi = 1'b0;
        // The first set bit seen wins the position; any later one marks multi-hot.
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    pos = N'(i);
                end
                any = 1'b1;
            end
        end
        one = any & ~multi;
    end

endmodule

// File: rtl/req_encoder_nbit.sv
// Sequential multi-hot to binary encoder: captures a request vector, then
// hands out the index of each set bit, lowest first, one per handshake.
module req_encoder_nbit
    import req_encoder_nbit_pkg::*;
#(
    parameter int N = 3,
    localparam int W = vec_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [0:W-1] req,
    output logic         load_ready,
    output logic         idx_valid,
    output logic [N-1:0] idx,
    input  logic         idx_ready,
    output logic         idx_last,
    output logic [N:0]   count
);

    logic         state_q, state_d;
    logic [0:W-1] pending_q, pending_d;

    logic [N-1:0] low_pos;
    logic         low_any;
    logic         low_one;
    logic [N:0]   pop_cnt;
    logic         scan;

    lsb_find_nbit #(.N(N)) u_lsb_find (
        .v   (pending_q),
        .pos (low_pos),
        .any (low_any),
        .one (low_one)
    );

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < W; i++) begin
            pop_cnt = pop_cnt + (N + 1)'(pending_q[i]);
        end
    end

    // Outputs depend only on registered state; forced to zero outside SCAN.
    assign scan       = (state_q == ST_SCAN);
    assign load_ready = ~scan;
    assign idx_valid  = scan;
    assign idx        = scan ? low_pos : '0;
    assign idx_last   = scan & low_one;
    assign count      = scan ? pop_cnt : '0;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (state_q == ST_IDLE) begin
            if (load) begin
                pending_d = req;
                if (req != '0) begin
                    state_d = ST_SCAN;
                end
            end
        end else if (idx_ready) begin
            pending_d[low_pos] = 1'b0;
            if (low_one || !low_any) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
